ones_pattern_gen: RTL and testbench
===================================

// Module: ones_pattern_gen
// PURPOSE
//  Inverse of the ones-counter: converts a 5-bit ones count NUMBER into a LENGTH-bit
//  word O containing exactly that many 1s, packed into the MSBs (thermometer form).
//  The word is built serially in a shift register, one bit per clock, under a
//  START/BUSY/DONE handshake. Used to generate reference patterns for the counter.
//  Round trip: popcount(O) == min(NUMBER, LENGTH).
// PARAMETERS
//  LENGTH  16  output word width; legal range 2..31 (NUMBER is fixed at 5 bits)
// PORTS
//  CLK     in   1       single clock, rising edge
//  RST_N   in   1       asynchronous, active-low reset
//  START   in   1       request; sampled only in IDLE
//  NUMBER  in   5       requested ones count; sampled with START
//  BUSY    out  1       high while a request is in progress (state != IDLE)
//  DONE    out  1       one-cycle pulse; O and OVF are valid and updated
//  O       out  LENGTH  result word; holds its value until the next DONE
//  OVF     out  1       last request had NUMBER > LENGTH (result saturated)
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE; O=0, OVF=0, DONE=0, BUSY=0;
//   shift reg, bit counter and latched count all 0. Mid-operation reset aborts
//   the request; no DONE is produced.
//  FSM (registered state; BUSY/DONE decoded from state):
//   IDLE : START=1 at edge k -> SHIFT; latch n = min(NUMBER, LENGTH);
//          latch ovf = (NUMBER > LENGTH); clear sr, cnt=0. START=0 -> stay.
//   SHIFT: each edge: sr <= {sr[LENGTH-2:0], (cnt < n)}; cnt <= cnt+1.
//          After LENGTH shifts (cnt reaches LENGTH) -> DONE_ST, and on the same edge
//          O <= final sr and OVF <= ovf.
//   DONE_ST: DONE=1, BUSY=1 for exactly one cycle -> IDLE unconditionally.
//  Timing: START sampled at edge k; BUSY high in cycles k+1..k+LENGTH+1;
//   DONE high in cycle k+LENGTH+1 (LENGTH+1 cycles total; 17 for default).
//   Next START accepted at edge k+LENGTH+2 at the earliest.
//  START while BUSY (including DONE_ST) is ignored, not queued.
//  NUMBER changes after the sampling edge have no effect on the current request.
//  Bit order: the first shifted bit ends up at O[LENGTH-1], so
//   O[LENGTH-1 -: n] = all 1s and the remaining LSBs = 0. n=0 -> O=0; n=LENGTH -> all 1s.
//  O and OVF update only on the SHIFT->DONE_ST edge and remain stable while BUSY
//   (the previous result stays visible).
//  Counter width: cnt is 5 bits. The comparison cnt < n is unsigned; there is no wrap,
//   because LENGTH <= 31.
// TESTING
//  1 Reset: RST_N=0 -> O=0, OVF=0, DONE=0, BUSY=0, independent of CLK.
//  2 NUMBER=5, START 1 cycle -> DONE at cycle 17; O=16'hF800, OVF=0; BUSY for 17 cycles.
//  3 Boundaries: NUMBER=0 -> O=16'h0000. NUMBER=16 -> O=16'hFFFF, OVF=0.
//    NUMBER=20 -> O=16'hFFFF, OVF=1.
//  4 START held high continuously with NUMBER=3 -> one DONE per 18 cycles,
//    O=16'hE000 each time. Change NUMBER to 9 mid-request -> current result still 16'hE000.
//  5 Assert RST_N=0 at cycle 8 of a request -> no DONE, O=0. The next request completes normally.
//  6 Sweep NUMBER 0..31 through the ones counter -> the count equals min(NUMBER,16)
//    and OVF = (NUMBER > 16).

Source files
------------

// File: rtl/ones_pattern_gen.sv
// Serial thermometer-code generator: turns a ones count into a LENGTH-bit word
// with that many 1s packed into the MSBs, one bit shifted in per clock.
module ones_pattern_gen #(
  parameter int unsigned LENGTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [4:0]        number_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LENGTH-1:0] o_o,
  output logic              ovf_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE_ST = 2'd2
  } state_e;

  localparam logic [4:0] LEN5 = 5'(LENGTH);
  localparam logic [4:0] LAST = 5'(LENGTH - 1);

  state_e              state_q, state_d;
  logic [LENGTH-1:0]   sr_q, sr_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [4:0]          n_q, n_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [LENGTH-1:0]   o_q, o_d;
  logic                ovf_q, ovf_d;

  // NOTE: every reg gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    ovf_pend_d = ovf_pend_q;
    o_d        = o_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = SHIFT;
          n_d        = (number_i > LEN5) ? LEN5 : number_i;
          ovf_pend_d = (number_i > LEN5);
          sr_d       = '0;
          cnt_d      = '0;
        end
      end
      SHIFT: begin
        sr_d  = {sr_q[LENGTH-2:0], (cnt_q < n_q)};
        cnt_d = cnt_q + 5'd1;
        // The last shift publishes the finished word directly, so O is valid with DONE.
        if (cnt_q == LAST) begin
          state_d = DONE_ST;
          o_d     = sr_d;
          ovf_d   = ovf_pend_q;
        end
      end
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all regs update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      n_q        <= '0;
      ovf_pend_q <= 1'b0;
      o_q        <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      ovf_pend_q <= ovf_pend_d;
      o_q        <= o_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE_ST);
  assign o_o    = o_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Bench for ones_pattern_gen: directed boundary cases plus a randomized sweep
// compared against an arithmetic model of the thermometer word.
module tb_ones_pattern_gen;

  localparam int LEN = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [4:0]     number;
  logic           busy, done, ovf;
  logic [LEN-1:0] o;

  int n_pass  = 0;
  int n_total = 0;

  ones_pattern_gen #(.LENGTH(LEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .number_i (number),
    .busy_o   (busy),
    .done_o   (done),
    .o_o      (o),
    .ovf_o    (ovf)
  );

  always #5 clk = ~clk;

  // Expected word: min(num, LEN) ones at the top, built from a shifted mask.
  function automatic logic [LEN-1:0] model_word(input int num);
    int          n;
    logic [31:0] w;
    n = (num > LEN) ? LEN : num;
    w = ((32'd1 << n) - 32'd1) << (LEN - n);
    return w[LEN-1:0];
  endfunction

  // Issues one request and follows it until DONE (bounded). lat = cycle index
  // of DONE after the sampling edge, 0 on timeout. Optional START noise while busy.
  task automatic do_request(input logic [4:0] num, input bit noise,
                            output int lat, output bit busy_gap, output bit o_moved);
    logic [LEN-1:0] o_prev;
    o_prev   = o;
    lat      = 0;
    busy_gap = 0;
    o_moved  = 0;
    start    = 1'b1;
    number   = num;
    @(negedge clk);
    start  = 1'b0;
    number = 5'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (!busy) busy_gap = 1;
      if (done) begin
        lat = c;
        break;
      end
      if (o !== o_prev) o_moved = 1;
      start  = noise ? 1'($urandom) : 1'b0;
      number = 5'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    bit gap, moved;
    rst_n  = 1'b0;
    start  = 1'b0;
    number = '0;
    #2;
    n_total++;
    if ({busy, done, ovf, o} !== '0) $display("FAIL reset_initial: got busy=%b done=%b ovf=%b o=%h expected all 0", busy, done, ovf, o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_request(5'd11, 1'b0, lat, gap, moved);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, ovf, o} !== '0) $display("FAIL reset_async: got busy=%b done=%b ovf=%b o=%h expected all 0", busy, done, ovf, o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    bit gap, moved;
    do_request(5'd5, 1'b0, lat, gap, moved);
    n_total++;
    if (lat !== 17) $display("FAIL basic_latency: got %0d expected 17", lat);
    else n_pass++;
    n_total++;
    if (gap || moved) $display("FAIL basic_busy_hold: got busy_gap=%b o_moved=%b expected 0 0", gap, moved);
    else n_pass++;
    n_total++;
    if (o !== 16'hF800 || ovf !== 1'b0) $display("FAIL basic_word: got o=%h ovf=%b expected o=f800 ovf=0", o, ovf);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL basic_after: got busy=%b done=%b expected 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_boundaries();
    int          lat;
    bit          gap, moved;
    logic [4:0]  nums[3]  = '{5'd0, 5'd16, 5'd20};
    logic [15:0] words[3] = '{16'h0000, 16'hFFFF, 16'hFFFF};
    logic        ovfs[3]  = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_request(nums[i], 1'b0, lat, gap, moved);
      n_total++;
      if (lat !== 17 || o !== words[i] || ovf !== ovfs[i])
        $display("FAIL boundary_n%0d: got lat=%0d o=%h ovf=%b expected lat=17 o=%h ovf=%b",
                 nums[i], lat, o, ovf, words[i], ovfs[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int dones[$];
    logic [15:0] words[$];
    start  = 1'b1;
    number = 5'd3;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 40) number = 5'd9;
      if (done) begin
        dones.push_back(c);
        words.push_back(o);
        if (dones.size() == 3) break;
      end
    end
    start = 1'b0;
    n_total++;
    if (dones.size() != 3) $display("FAIL b2b_count: got %0d dones expected 3", dones.size());
    else n_pass++;
    for (int i = 0; i < dones.size(); i++) begin
      n_total++;
      if (dones[i] != 17 + 18 * i || words[i] !== 16'hE000)
        $display("FAIL b2b_done%0d: got cycle=%0d o=%h expected cycle=%0d o=e000",
                 i, dones[i], words[i], 17 + 18 * i);
      else n_pass++;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int lat;
    bit gap, moved, saw_done;
    logic [4:0] num;
    do_request(5'd7, 1'b0, lat, gap, moved);
    @(negedge clk);
    start  = 1'b1;
    number = 5'd12;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, ovf, o} !== '0) $display("FAIL midreset_clear: got busy=%b done=%b ovf=%b o=%h expected all 0", busy, done, ovf, o);
    else n_pass++;
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    n_total++;
    if (saw_done || o !== '0) $display("FAIL midreset_abort: got activity=%b o=%h expected 0 0000", saw_done, o);
    else n_pass++;
    num = 5'($urandom_range(1, 15));
    do_request(num, 1'b0, lat, gap, moved);
    n_total++;
    if (lat !== 17 || o !== model_word(int'(num)))
      $display("FAIL midreset_next: got lat=%0d o=%h expected lat=17 o=%h", lat, o, model_word(int'(num)));
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int          lat, j, exp_cnt;
    bit          gap, moved;
    logic [4:0]  order[32];
    logic [4:0]  tmp;
    for (int i = 0; i < 32; i++) order[i] = 5'(i);
    for (int i = 31; i > 0; i--) begin
      j        = int'($urandom_range(0, i));
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 32; i++) begin
      do_request(order[i], 1'b1, lat, gap, moved);
      exp_cnt = (int'(order[i]) > LEN) ? LEN : int'(order[i]);
      n_total++;
      if (lat !== 17 || gap || moved)
        $display("FAIL sweep_timing_n%0d: got lat=%0d gap=%b moved=%b expected 17 0 0", order[i], lat, gap, moved);
      else n_pass++;
      n_total++;
      if ($countones(o) != exp_cnt || o !== model_word(int'(order[i])) || ovf !== (int'(order[i]) > LEN))
        $display("FAIL sweep_word_n%0d: got o=%h ovf=%b expected o=%h ovf=%b",
                 order[i], o, ovf, model_word(int'(order[i])), (int'(order[i]) > LEN));
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (busy !== 1'b0) $display("FAIL sweep_idle_n%0d: got busy=%b expected 0", order[i], busy);
      else n_pass++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_mid_reset();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
